// File: rtl/dram_responder.sv
// dram_responder: target-side responder for the core's dram data bus.
//   Byte-writable word RAM with programmable wait states and error signalling.
//   The top three RAM words also drive shadow registers for test control:
//   HALT (MEM_SIZE_WORDS-3), SIG_END (MEM_SIZE_WORDS-2), SIG_START (MEM_SIZE_WORDS-1).
//
// RAM contents are undefined until written; shadows follow bus writes only.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   stb_i        request strobe, one-cycle pulse per transaction
//   we_i         byte write enables, 4'b0000 = read
//   addr_i       byte address, bits [1:0] ignored
//   wdata_i      lane-aligned write data
//   rdata_o      read data, non-zero only during ack_o of a read
//   ack_o        one-cycle pulse, transaction completed
//   err_o        one-cycle pulse, transaction rejected
//   halt_o       sticky, set when 32'h1 lands in the HALT word
//   sig_start_o  shadow of the SIG_START word
//   sig_end_o    shadow of the SIG_END word

module dram_responder #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned MEM_SIZE_WORDS = 1024,
   parameter int unsigned WAIT_STATES    = 0,
   parameter string       MEM_INIT_FILE  = "out.hex"
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stb_i,
   input  logic [3:0]            we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  ack_o,
   output logic                  err_o,
   output logic                  halt_o,
   output logic [ADDR_WIDTH-1:0] sig_start_o,
   output logic [ADDR_WIDTH-1:0] sig_end_o
);

   localparam int unsigned IDX_W    = $clog2(MEM_SIZE_WORDS);
   localparam int unsigned IDX_LSB  = 2;
   localparam int unsigned HI_LSB   = IDX_W + IDX_LSB;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned LANES    = 4;

   localparam logic [IDX_W-1:0] HALT_IDX      = IDX_W'(MEM_SIZE_WORDS - 3);
   localparam logic [IDX_W-1:0] SIG_END_IDX   = IDX_W'(MEM_SIZE_WORDS - 2);
   localparam logic [IDX_W-1:0] SIG_START_IDX = IDX_W'(MEM_SIZE_WORDS - 1);

   // Counter preload; only meaningful when wait states are configured.
   localparam logic [CNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : CNT_W'(0);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]            state_q;
   logic [1:0]            state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;

   logic [3:0]            we_q;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  bad_q;

   logic                  accept_c;
   logic                  oor_c;
   logic                  we_ok_c;
   logic                  commit_c;
   logic                  wr_c;
   logic                  rd_c;
   logic [DATA_WIDTH-1:0] old_word_c;
   logic [DATA_WIDTH-1:0] merged_c;
   logic                  addr_unused_c;

   logic [DATA_WIDTH-1:0] mem [MEM_SIZE_WORDS];

   // Byte offset within the word is irrelevant on this bus.
   assign addr_unused_c = ^addr_i[IDX_LSB-1:0];

   // Request qualification: out-of-range address or unsupported lane mask.
   assign oor_c = |addr_i[ADDR_WIDTH-1:HI_LSB];

   always_comb begin
      we_ok_c = 1'b0;
      case (we_i)
         4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: we_ok_c = 1'b1;
         default:                   we_ok_c = 1'b0;
      endcase
   end

   // Requests arriving while busy are dropped without any response.
   assign accept_c = (state_q == ST_IDLE) && stb_i;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               cnt_d   = WAIT_LOAD;
               state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Request capture at accept.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q    <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         bad_q   <= 1'b0;
      end else if (accept_c) begin
         we_q    <= we_i;
         idx_q   <= addr_i[HI_LSB-1:IDX_LSB];
         wdata_q <= wdata_i;
         bad_q   <= oor_c || !we_ok_c;
      end
   end

   // The edge leaving RESP is the commit edge: it raises ack_o/err_o,
   // writes the RAM and samples read data.
   assign commit_c   = (state_q == ST_RESP) && !bad_q;
   assign wr_c       = commit_c && (we_q != 4'b0000);
   assign rd_c       = commit_c && (we_q == 4'b0000);
   assign old_word_c = mem[idx_q];

   // Word as it will look after the write; feeds the shadow registers.
   always_comb begin
      merged_c = old_word_c;
      for (int b = 0; b < LANES; b++) begin
         if (we_q[b]) begin
            merged_c[8*b +: 8] = wdata_q[8*b +: 8];
         end
      end
   end

   // RAM array; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (wr_c) begin
         for (int b = 0; b < LANES; b++) begin
            if (we_q[b]) begin
               mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

   // Registered bus response and control shadows.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_o     <= '0;
         ack_o       <= 1'b0;
         err_o       <= 1'b0;
         halt_o      <= 1'b0;
         sig_start_o <= '0;
         sig_end_o   <= '0;
      end else begin
         ack_o   <= commit_c;
         err_o   <= (state_q == ST_RESP) && bad_q;
         rdata_o <= rd_c ? old_word_c : '0;
         if (wr_c && (idx_q == SIG_START_IDX)) begin
            sig_start_o <= ADDR_WIDTH'(merged_c);
         end
         if (wr_c && (idx_q == SIG_END_IDX)) begin
            sig_end_o <= ADDR_WIDTH'(merged_c);
         end
         // Sticky: later overwrites of HALT never clear it.
         if (wr_c && (idx_q == HALT_IDX) && (merged_c == DATA_WIDTH'(1))) begin
            halt_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dram_responder.sv
// Directed self-checking bench for dram_responder.
// Three instances share clock, reset and request fields, each with its own
// strobe: WAIT_STATES = 0, 3 and 5.

module tb_dram_responder;

   logic        clk;
   logic        rst;
   logic [2:0]  stb;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata [3];
   logic [2:0]  ack;
   logic [2:0]  err;
   logic [2:0]  halt;
   logic [31:0] sig_start [3];
   logic [31:0] sig_end [3];

   int checks;
   int errors;

   dram_responder #(.WAIT_STATES(0)) u_ws0 (
      .clk_i(clk), .rst_i(rst), .stb_i(stb[0]), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .rdata_o(rdata[0]), .ack_o(ack[0]), .err_o(err[0]),
      .halt_o(halt[0]), .sig_start_o(sig_start[0]), .sig_end_o(sig_end[0]));

   dram_responder #(.WAIT_STATES(3)) u_ws3 (
      .clk_i(clk), .rst_i(rst), .stb_i(stb[1]), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .rdata_o(rdata[1]), .ack_o(ack[1]), .err_o(err[1]),
      .halt_o(halt[1]), .sig_start_o(sig_start[1]), .sig_end_o(sig_end[1]));

   dram_responder #(.WAIT_STATES(5)) u_ws5 (
      .clk_i(clk), .rst_i(rst), .stb_i(stb[2]), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .rdata_o(rdata[2]), .ack_o(ack[2]), .err_o(err[2]),
      .halt_o(halt[2]), .sig_start_o(sig_start[2]), .sig_end_o(sig_end[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction on instance sel; lat = cycles from accept edge to the
   // response, 0 if none arrived within the budget.
   task automatic xact(input int sel, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic ak, output logic er, output int lat);
      @(negedge clk);
      we = w; addr = a; wdata = d; stb[sel] = 1'b1;
      @(posedge clk);
      #1 stb[sel] = 1'b0;
      rd = '0; ak = 1'b0; er = 1'b0; lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (ack[sel] || err[sel]) begin
            rd = rdata[sel]; ak = ack[sel]; er = err[sel]; lat = c;
            break;
         end
      end
   endtask

   task automatic op(input string tag, input int sel, input logic [3:0] w,
                     input logic [31:0] a, input logic [31:0] d, input logic exp_ack,
                     input logic [31:0] exp_rd, input int exp_lat);
      logic [31:0] rd;
      logic        ak, er;
      int          lat;
      xact(sel, w, a, d, rd, ak, er, lat);
      chk({tag, "_ack"}, 32'(ak), 32'(exp_ack));
      chk({tag, "_err"}, 32'(er), 32'(!exp_ack));
      chk({tag, "_rdata"}, rd, exp_rd);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      int acks, errs, first, resp;
      checks = 0; errors = 0;
      rst = 1'b1; stb = '0; we = '0; addr = '0; wdata = '0;

      // Reset state of every instance.
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_ack", 32'(ack[i]), 32'h0);
         chk("rst_err", 32'(err[i]), 32'h0);
         chk("rst_rdata", rdata[i], 32'h0);
         chk("rst_halt", 32'(halt[i]), 32'h0);
         chk("rst_sig_start", sig_start[i], 32'h0);
         chk("rst_sig_end", sig_end[i], 32'h0);
      end
      @(negedge clk) rst = 1'b0;

      // Zero wait states: one cycle latency.
      op("ws0_wr", 0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1);
      op("ws0_rd", 0, 4'h0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1);
      @(posedge clk); #1;
      chk("ws0_rdata_after", rdata[0], 32'h0);

      // Byte lanes and an illegal lane mask.
      op("bl_fill", 0, 4'hF, 32'h20, 32'h11223344, 1'b1, 32'h0, 1);
      op("bl_wr", 0, 4'b0100, 32'h20, 32'h00AA0000, 1'b1, 32'h0, 1);
      op("bl_rd", 0, 4'h0, 32'h20, 32'h0, 1'b1, 32'h11AA3344, 1);
      op("bl_badwe", 0, 4'b0101, 32'h20, 32'hFFFFFFFF, 1'b0, 32'h0, 1);
      op("bl_rd2", 0, 4'h0, 32'h20, 32'h0, 1'b1, 32'h11AA3344, 1);
      op("bl_hi", 0, 4'b1100, 32'h22, 32'h5566FFFF, 1'b1, 32'h0, 1);
      op("bl_rd3", 0, 4'h0, 32'h20, 32'h0, 1'b1, 32'h55663344, 1);

      // Three wait states; a strobe two cycles into the wait is dropped.
      op("ws3_wr", 1, 4'hF, 32'h40, 32'hCAFEF00D, 1'b1, 32'h0, 4);
      @(negedge clk);
      we = 4'h0; addr = 32'h40; stb[1] = 1'b1;
      @(posedge clk);
      #1 stb[1] = 1'b0;
      acks = 0; errs = 0; first = 0; resp = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         stb[1] = (c == 2);
         @(posedge clk);
         #1;
         if (ack[1]) begin
            acks++;
            if (first == 0) begin
               first = c;
               resp  = rdata[1];
            end
         end
         if (err[1]) errs++;
      end
      stb[1] = 1'b0;
      chk("ws3_acks", 32'(acks), 32'd1);
      chk("ws3_errs", 32'(errs), 32'd0);
      chk("ws3_lat", 32'(first), 32'd4);
      chk("ws3_rdata", 32'(resp), 32'hCAFEF00D);

      // Out of range accesses must not alias onto word 0.
      op("oor_fill", 0, 4'hF, 32'h0, 32'h01234567, 1'b1, 32'h0, 1);
      op("oor_rd", 0, 4'h0, 32'h1000, 32'h0, 1'b0, 32'h0, 1);
      op("oor_wr", 0, 4'hF, 32'h1000, 32'hFFFFFFFF, 1'b0, 32'h0, 1);
      op("oor_rd0", 0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h01234567, 1);
      op("oor_top", 0, 4'h0, 32'h80000FFC, 32'h0, 1'b0, 32'h0, 1);

      // Control cells.
      op("cc_start", 0, 4'hF, 32'hFFC, 32'h2000, 1'b1, 32'h0, 1);
      op("cc_end", 0, 4'hF, 32'hFF8, 32'h2040, 1'b1, 32'h0, 1);
      chk("cc_sig_start", sig_start[0], 32'h2000);
      chk("cc_sig_end", sig_end[0], 32'h2040);
      chk("cc_halt_pre", 32'(halt[0]), 32'h0);
      op("cc_start_b0", 0, 4'b0001, 32'hFFC, 32'h000000AA, 1'b1, 32'h0, 1);
      chk("cc_sig_start_merge", sig_start[0], 32'h20AA);
      op("cc_halt2", 0, 4'hF, 32'hFF4, 32'h2, 1'b1, 32'h0, 1);
      chk("cc_halt_two", 32'(halt[0]), 32'h0);
      op("cc_halt1", 0, 4'hF, 32'hFF4, 32'h1, 1'b1, 32'h0, 1);
      chk("cc_halt_set", 32'(halt[0]), 32'h1);
      op("cc_halt0", 0, 4'hF, 32'hFF4, 32'h0, 1'b1, 32'h0, 1);
      chk("cc_halt_sticky", 32'(halt[0]), 32'h1);
      chk("cc_other_inst", sig_start[1], 32'h0);

      // Reset in the middle of a five-wait-state write.
      op("rm_fill", 2, 4'hF, 32'h30, 32'h11, 1'b1, 32'h0, 6);
      @(negedge clk);
      we = 4'hF; addr = 32'h30; wdata = 32'h55; stb[2] = 1'b1;
      @(posedge clk);
      #1 stb[2] = 1'b0;
      resp = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         if (ack[2] || err[2]) resp++;
         if (c == 2) rst = 1'b1;
      end
      chk("rm_rdata", rdata[2], 32'h0);
      chk("rm_halt0", 32'(halt[0]), 32'h0);
      chk("rm_sig_start0", sig_start[0], 32'h0);
      @(negedge clk) rst = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (ack[2] || err[2]) resp++;
      end
      chk("rm_no_resp", 32'(resp), 32'd0);
      op("rm_rd", 2, 4'h0, 32'h30, 32'h0, 1'b1, 32'h11, 6);
      op("rm_ws0_rd", 0, 4'h0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
